// File: rtl/axi_unescape_tlast_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_unescape_tlast_if
//  Brief    : Stream bundle for the TLAST unescaper: the escaped input stream
//             (no TLAST) and the decoded output stream (with TLAST).
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_unescape_tlast_if #(
  parameter int WIDTH = 64
) ();

  logic [WIDTH-1:0] i_tdata;
  logic             i_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  // Decoder view: sinks the escaped stream, sources the decoded stream.
  modport slave (
    input  i_tdata, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  // Environment view: sources the escaped stream, sinks the decoded stream.
  modport master (
    output i_tdata, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );

endinterface
`default_nettype wire

// File: rtl/axi_unescape_tlast.sv
`default_nettype none
// ============================================================================
//  Module   : axi_unescape_tlast
//  Brief    : Decodes an escaped stream without TLAST into an AXI stream with
//             TLAST. ESC,1,W -> W with tlast; ESC,0,W -> W as plain data.
//             Registered output stage, illegal-code detection, optional XOR
//             checksum validation and saturating error counters.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_unescape_tlast #(
  parameter int          WIDTH             = 64,
  parameter logic [63:0] ESC_WORD          = 64'hDEADBEEFFEEDCAFE,
  parameter bit          VALIDATE_CHECKSUM = 1'b0,
  parameter int          CNT_W             = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             clear,
  axi_unescape_tlast_if.slave   bus,
  output logic                  checksum_error,
  output logic                  code_error,
  output logic [CNT_W-1:0]      checksum_err_cnt,
  output logic [CNT_W-1:0]      code_err_cnt
);

  localparam int               H         = WIDTH / 2;
  localparam logic [WIDTH-1:0] C_ESC     = WIDTH'(ESC_WORD);
  localparam logic [H-1:0]     C_CODE_DT = '0;
  localparam logic [H-1:0]     C_CODE_LS = H'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ESC_SEEN  = 2'd1,
    S_LAST_WORD = 2'd2,
    S_DATA_WORD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] o_tdata_q, o_tdata_d;
  logic             o_tlast_q, o_tlast_d;
  logic             o_tvalid_q, o_tvalid_d;
  logic [H-1:0]     checksum_q, checksum_d;
  logic             checksum_error_q, checksum_error_d;
  logic             code_error_q, code_error_d;
  logic [CNT_W-1:0] checksum_err_cnt_q, checksum_err_cnt_d;
  logic [CNT_W-1:0] code_err_cnt_q, code_err_cnt_d;

  logic [H-1:0]     w_lo, w_hi;
  logic             w_is_esc;
  logic             w_slot_free;
  logic             w_ready;
  logic             w_fwd;
  logic             w_fwd_last;

  assign w_lo        = bus.i_tdata[H-1:0];
  assign w_hi        = bus.i_tdata[WIDTH-1:H];
  assign w_is_esc    = (bus.i_tdata == C_ESC);
  assign w_slot_free = ~o_tvalid_q | bus.o_tready;

  // Escape-sequence FSM: input ready, forwarding decision and error detection.
  always_comb begin
    state_d          = state_q;
    w_ready          = w_slot_free;
    w_fwd            = 1'b0;
    w_fwd_last       = 1'b0;
    checksum_error_d = 1'b0;
    code_error_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_tvalid && w_is_esc) begin
          // ESC is swallowed regardless of output backpressure.
          w_ready = 1'b1;
          state_d = S_ESC_SEEN;
        end else begin
          w_fwd = bus.i_tvalid & w_slot_free;
        end
      end
      S_ESC_SEEN: begin
        // Code word is never forwarded, so it never waits on the output.
        w_ready = 1'b1;
        if (bus.i_tvalid) begin
          if (w_lo == C_CODE_LS) begin
            state_d = S_LAST_WORD;
            if (VALIDATE_CHECKSUM && (w_hi != checksum_q)) begin
              checksum_error_d = 1'b1;
            end
          end else if (w_lo == C_CODE_DT) begin
            state_d = S_DATA_WORD;
          end else begin
            code_error_d = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_LAST_WORD: begin
        w_fwd      = bus.i_tvalid & w_slot_free;
        w_fwd_last = 1'b1;
        if (w_fwd) state_d = S_IDLE;
      end
      S_DATA_WORD: begin
        w_fwd = bus.i_tvalid & w_slot_free;
        if (w_fwd) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output pipeline register, running checksum and saturating error counters.
  always_comb begin
    o_tvalid_d         = o_tvalid_q & ~bus.o_tready;
    o_tdata_d          = o_tdata_q;
    o_tlast_d          = o_tlast_q;
    checksum_d         = checksum_q;
    checksum_err_cnt_d = checksum_err_cnt_q;
    code_err_cnt_d     = code_err_cnt_q;
    if (w_fwd) begin
      o_tvalid_d = 1'b1;
      o_tdata_d  = bus.i_tdata;
      o_tlast_d  = w_fwd_last;
    end
    if (!VALIDATE_CHECKSUM) begin
      checksum_d = '0;
    end else if (w_fwd) begin
      checksum_d = w_fwd_last ? '0 : (checksum_q ^ w_lo ^ w_hi);
    end
    // A clear suppresses the pulse, so the counter must not see it either.
    if (checksum_error_d && !clear && (checksum_err_cnt_q != '1)) begin
      checksum_err_cnt_d = checksum_err_cnt_q + CNT_W'(1);
    end
    if (code_error_d && !clear && (code_err_cnt_q != '1)) begin
      code_err_cnt_d = code_err_cnt_q + CNT_W'(1);
    end
  end

  // State register: reset clears everything, clear keeps only the counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= S_IDLE;
      o_tdata_q          <= '0;
      o_tlast_q          <= 1'b0;
      o_tvalid_q         <= 1'b0;
      checksum_q         <= '0;
      checksum_error_q   <= 1'b0;
      code_error_q       <= 1'b0;
      checksum_err_cnt_q <= '0;
      code_err_cnt_q     <= '0;
    end else begin
      checksum_err_cnt_q <= checksum_err_cnt_d;
      code_err_cnt_q     <= code_err_cnt_d;
      if (clear) begin
        state_q          <= S_IDLE;
        o_tdata_q        <= '0;
        o_tlast_q        <= 1'b0;
        o_tvalid_q       <= 1'b0;
        checksum_q       <= '0;
        checksum_error_q <= 1'b0;
        code_error_q     <= 1'b0;
      end else begin
        state_q          <= state_d;
        o_tdata_q        <= o_tdata_d;
        o_tlast_q        <= o_tlast_d;
        o_tvalid_q       <= o_tvalid_d;
        checksum_q       <= checksum_d;
        checksum_error_q <= checksum_error_d;
        code_error_q     <= code_error_d;
      end
    end
  end

  assign bus.i_tready     = w_ready;
  assign bus.o_tdata      = o_tdata_q;
  assign bus.o_tlast      = o_tlast_q;
  assign bus.o_tvalid     = o_tvalid_q;
  assign checksum_error   = checksum_error_q;
  assign code_error       = code_error_q;
  assign checksum_err_cnt = checksum_err_cnt_q;
  assign code_err_cnt     = code_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_unescape_tlast.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_unescape_tlast
//  Brief    : Scoreboard bench for axi_unescape_tlast with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_unescape_tlast;

  localparam int          WIDTH = 64;
  localparam int          CNT_W = 10;
  localparam logic [63:0] ESC   = 64'hDEADBEEFFEEDCAFE;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             checksum_error, code_error;
  logic [CNT_W-1:0] checksum_err_cnt, code_err_cnt;

  axi_unescape_tlast_if #(.WIDTH(WIDTH)) bus ();

  axi_unescape_tlast #(
    .WIDTH(WIDTH), .ESC_WORD(ESC), .VALIDATE_CHECKSUM(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus),
    .checksum_error(checksum_error), .code_error(code_error),
    .checksum_err_cnt(checksum_err_cnt), .code_err_cnt(code_err_cnt)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  exp_t        e_cur;
  int          checks = 0;
  int          failures = 0;
  int          cs_pulses = 0;
  int          ce_pulses = 0;
  bit          rand_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] prev_d;
  logic        prev_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [63:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  // Present one word; returns the number of cycles spent waiting for ready.
  task automatic send(input logic [63:0] w, output int waited);
    waited = 0;
    bus.i_tdata  = w;
    bus.i_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.i_tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 for word %0h", w);
    end
    @(posedge clk);
    #1;
    bus.i_tvalid = 1'b0;
  endtask

  task automatic send_seq(input logic [63:0] ws[], output int total);
    int w;
    total = 0;
    foreach (ws[i]) begin
      send(ws[i], w);
      total += w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks hold stability.
  always @(negedge clk) begin
    if (reset_n && !clear) begin
      if (stall_prev && bus.o_tvalid) begin
        check("hold_data", bus.o_tdata, prev_d);
        check("hold_last", {63'b0, bus.o_tlast}, {63'b0, prev_l});
      end
      if (bus.o_tvalid && bus.o_tready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %0h expected none", bus.o_tdata);
        end else begin
          e_cur = q.pop_front();
          check("out_data", bus.o_tdata, e_cur.d);
          check("out_last", {63'b0, bus.o_tlast}, {63'b0, e_cur.l});
        end
      end
      stall_prev = bus.o_tvalid & ~bus.o_tready;
      prev_d     = bus.o_tdata;
      prev_l     = bus.o_tlast;
    end else begin
      stall_prev = 1'b0;
    end
    if (checksum_error) cs_pulses++;
    if (code_error) ce_pulses++;
  end

  // Random output backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.o_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    logic [63:0] seq[];
    bus.i_tdata  = '0;
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_tvalid", {63'b0, bus.o_tvalid}, 64'd0);
    check("rst_o_tdata", bus.o_tdata, 64'd0);
    check("rst_o_tlast", {63'b0, bus.o_tlast}, 64'd0);
    check("rst_i_tready", {63'b0, bus.i_tready}, 64'd1);
    check("rst_cs_cnt", 64'(checksum_err_cnt), 64'd0);
    check("rst_ce_cnt", 64'(code_err_cnt), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: A, B, ESC, 1, C -> A, B, C(last); checksum A^B folds to 0.
    expect_out(64'h11111111_22222222, 1'b0);
    expect_out(64'h00000000_33333333, 1'b0);
    expect_out(64'h0123456789ABCDEF, 1'b1);
    seq = '{64'h11111111_22222222, 64'h00000000_33333333, ESC, 64'h1, 64'h0123456789ABCDEF};
    send_seq(seq, st);
    check("t1_no_stall", 64'(st), 64'd0);
    drain();

    // 2: ESC, 0, ESC, D, E -> ESC, D, E (all data).
    expect_out(ESC, 1'b0);
    expect_out(64'hD0D0D0D0_D0D0D0D0, 1'b0);
    expect_out(64'hE0E0E0E0_00000000, 1'b0);
    seq = '{ESC, 64'h0, ESC, 64'hD0D0D0D0_D0D0D0D0, 64'hE0E0E0E0_00000000};
    send_seq(seq, st);
    drain();
    pulse_clear();

    // 3: ESC, 1, ESC -> ESC(last).
    expect_out(ESC, 1'b1);
    seq = '{ESC, 64'h1, ESC};
    send_seq(seq, st);
    drain();
    check("t3_cs_pulses", 64'(cs_pulses), 64'd0);

    // 4: checksum good (0x33), then bad (0x34).
    expect_out(64'h00000001_00000002, 1'b0);
    expect_out(64'h00000010_00000020, 1'b0);
    expect_out(64'hAAAA5555_AAAA5555, 1'b1);
    seq = '{64'h00000001_00000002, 64'h00000010_00000020, ESC, 64'h00000033_00000001, 64'hAAAA5555_AAAA5555};
    send_seq(seq, st);
    drain();
    check("t4_good_pulses", 64'(cs_pulses), 64'd0);
    check("t4_good_cnt", 64'(checksum_err_cnt), 64'd0);
    expect_out(64'h00000001_00000002, 1'b0);
    expect_out(64'h00000010_00000020, 1'b0);
    expect_out(64'hAAAA5555_AAAA5555, 1'b1);
    seq = '{64'h00000001_00000002, 64'h00000010_00000020, ESC, 64'h00000034_00000001, 64'hAAAA5555_AAAA5555};
    send_seq(seq, st);
    drain();
    check("t4_bad_pulses", 64'(cs_pulses), 64'd1);
    check("t4_bad_cnt", 64'(checksum_err_cnt), 64'd1);

    // 5: illegal code 5 is dropped, next word handled in IDLE; then saturate.
    expect_out(64'h5555_0000_0000_0001, 1'b0);
    seq = '{ESC, 64'h5, 64'h5555_0000_0000_0001};
    send_seq(seq, st);
    drain();
    check("t5_ce_pulses", 64'(ce_pulses), 64'd1);
    check("t5_ce_cnt", 64'(code_err_cnt), 64'd1);
    for (int i = 0; i < 1100; i++) begin
      send(ESC, st);
      send(ESC, st);
    end
    @(posedge clk);
    #1;
    check("t5_sat_pulses", 64'(ce_pulses), 64'd1101);
    check("t5_sat_cnt", 64'(code_err_cnt), 64'h3FF);
    drain();
    pulse_clear();

    // 6: random backpressure over two identical multi-packet streams.
    rand_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      expect_out(64'h0000000F_000000F0, 1'b0);
      expect_out(64'h1234_5678_9ABC_DEF0, 1'b1);
      expect_out(64'h00000000_00000001, 1'b0);
      expect_out(ESC, 1'b0);
      expect_out(64'hCCCC_CCCC_0000_0000, 1'b1);
      seq = '{64'h0000000F_000000F0, ESC, 64'h000000FF_00000001, 64'h1234_5678_9ABC_DEF0,
              64'h00000000_00000001, ESC, 64'h0, ESC, ESC, 64'h20407410_00000001,
              64'hCCCC_CCCC_0000_0000};
      send_seq(seq, st);
    end
    drain();
    rand_ready = 1'b0;
    bus.o_tready = 1'b1;
    check("t6_cs_pulses", 64'(cs_pulses), 64'd1);

    // Held output with ready low must not block ESC or code; LAST word waits.
    bus.o_tready = 1'b0;
    expect_out(64'h0000000F_000000F0, 1'b0);
    expect_out(64'h1234_5678_9ABC_DEF0, 1'b1);
    seq = '{64'h0000000F_000000F0, ESC, 64'h000000FF_00000001};
    send_seq(seq, st);
    check("t6_esc_no_stall", 64'(st), 64'd0);
    fork
      send(64'h1234_5678_9ABC_DEF0, st);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.o_tready = 1'b1;
      end
    join
    drain();

    // Clear in ESC_SEEN with a held word: both are discarded, counters kept.
    bus.o_tready = 1'b0;
    send(64'hBAD0_BAD0_BAD0_BAD0, st);
    send(ESC, st);
    pulse_clear();
    check("clr_o_tvalid", {63'b0, bus.o_tvalid}, 64'd0);
    check("clr_ce_cnt", 64'(code_err_cnt), 64'h3FF);
    check("clr_cs_cnt", 64'(checksum_err_cnt), 64'd1);
    bus.o_tready = 1'b1;
    expect_out(64'h1, 1'b0);
    expect_out(64'h2, 1'b0);
    seq = '{64'h1, 64'h2};
    send_seq(seq, st);
    drain();

    // Reset zeroes the counters.
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_ce_cnt", 64'(code_err_cnt), 64'd0);
    check("rst2_cs_cnt", 64'(checksum_err_cnt), 64'd0);
    check("rst2_o_tvalid", {63'b0, bus.o_tvalid}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("sb_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_unescape_tlast.md
Name: axi_unescape_tlast

Overview:
- Parametrised successor to the 64-bit in-band TLAST decoder.
- Converts an escaped WIDTH-bit AXI stream with no TLAST into a standard AXI stream with TLAST.
- Sequence rules:
  - ESC followed by code 1, then word W: emit W with o_tlast=1.
  - ESC followed by code 0, then word W: emit W as data.
- Adds a configurable ESC word, generic width, a registered output stage, illegal-code detection and saturating error counters.
- Sits at the receive side of transport links (e.g. chdr-over-serial) that cannot carry TLAST.

Parameters:
- WIDTH, 64, data width. Must be even and ≥ 32.
- ESC_WORD, 64'hDEADBEEFFEEDCAFE, escape word. Only the low WIDTH bits are used.
- VALIDATE_CHECKSUM, 0, when 1, compare the packet checksum carried in the code word.
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous, active-high; same effect as reset except the counters are kept.
- i_tdata  in  WIDTH  escaped input data.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  decoded data, registered.
- o_tlast  out  1  end of packet, registered.
- o_tvalid  out  1  output valid, registered.
- o_tready  in  1  output ready.
- checksum_error  out  1  one-cycle pulse on checksum mismatch.
- code_error  out  1  one-cycle pulse on an illegal code word.
- checksum_err_cnt  out  CNT_W  saturating count of checksum errors.
- code_err_cnt  out  CNT_W  saturating count of code errors.

Behaviour:

Definitions:
- H = WIDTH/2.
- lo = i_tdata[H-1:0], hi = i_tdata[WIDTH-1:H].
- acc = input handshake, i_tvalid & i_tready.
- slot_free = ~o_tvalid | o_tready.

Reset (reset_n=0) and clear:
- state=IDLE; o_tvalid=0; o_tlast=0; o_tdata=0; checksum=0; error pulses=0.
- Counters are zeroed only by reset_n, not by clear.
- Reset or clear mid-sequence discards any partially decoded ESC sequence and the held output word.

Output register:
- Standard single pipeline register with 1-cycle latency from acc to o_tvalid.
- Full throughput when o_tready=1.
- o_tdata and o_tlast hold stable while o_tvalid & ~o_tready.

FSM (4 states):
- IDLE
  - i_tvalid and i_tdata==ESC: i_tready=1. The word is consumed, not forwarded → ESC_SEEN.
  - Otherwise: i_tready=slot_free. On acc, forward the word with tlast=0, stay in IDLE.
- ESC_SEEN
  - i_tready=1; nothing is forwarded. Wait while i_tvalid=0.
  - lo==1: → LAST_WORD.
    - If VALIDATE_CHECKSUM and hi != checksum, pulse checksum_error the next cycle.
  - lo==0: → DATA_WORD.
  - Any other lo: pulse code_error the next cycle → IDLE. The code word is dropped.
- LAST_WORD
  - i_tready=slot_free. On acc, forward the word with tlast=1 → IDLE.
  - The word is forwarded even if it equals ESC.
- DATA_WORD
  - i_tready=slot_free. On acc, forward the word with tlast=0 → IDLE.
  - The word is forwarded even if it equals ESC.
  - This fixes the earlier generation's stall-to-LAST bug: DATA_WORD never transitions to LAST_WORD.

Checksum (H bits):
- On each forwarded word with tlast=0: checksum ^= lo ^ hi.
- Compared value = XOR over all non-final payload words of the packet. The final word is excluded; ESC and code words are never included.
- Reset to 0 on forwarding a tlast=1 word.
- With VALIDATE_CHECKSUM=0: checksum is held at 0, checksum_error is never asserted, and hi of the code word is ignored.

Counters:
- Increment by 1 on each corresponding error pulse.
- Saturate at 2^CNT_W-1.

Boundary conditions:
- Back-to-back ESC sequences and a packet of a single word (ESC,1,W) need no idle cycles.
- An ESC word arriving in LAST_WORD or DATA_WORD is data.
- o_tready low in ESC_SEEN does not stall the consumption of the code word.

Test Plan:
1. WIDTH=64, o_tready=1. Input: A, B, ESC, 0x…0001, C.
   → Output A, B, C with tlast only on C, 1-cycle latency, no bubbles except the 2 consumed words.
2. Input: ESC, 0x0, ESC, D.
   → Output ESC (tlast=0) then D (tlast=0), and the FSM returns to IDLE.
3. Input: ESC, 0x…0001, ESC.
   → Output ESC with tlast=1.
4. VALIDATE_CHECKSUM=1. Payload P0=0x00000001_00000002, P1=0x00000010_00000020, then ESC, code {hi=0x00000033, lo=1}, P2.
   → No error.
   - Repeat with hi=0x00000034 → checksum_error pulses for 1 cycle and checksum_err_cnt=1.
5. Code word lo=0x5.
   → code_error pulses and the next word is treated in IDLE.
   - Force 2^16 code errors → code_err_cnt saturates at 0xFFFF.
6. Random o_tready backpressure with o_tready=0 during LAST_WORD.
   → o_tdata and o_tlast stay stable and no words are lost.
   - Assert clear while in ESC_SEEN → state returns to IDLE, o_tvalid=0 next cycle, counters unchanged.
   - Assert reset_n=0 → counters are zeroed.
